// File: rtl/cordic_sched_if.sv
// rtl/cordic_sched_if.sv - request/response and core-side bundle for the shared CORDIC scheduler
interface cordic_sched_if #(
    parameter int NREQ = 4,
    parameter int XW   = 31,
    parameter int AW   = 27
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*XW-1:0] req_x;
    logic [NREQ*XW-1:0] req_y;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [AW-1:0]      rsp_angle;
    logic               rsp_err;
    logic               core_start;
    logic [XW-1:0]      core_x;
    logic [XW-1:0]      core_y;
    logic               core_done;
    logic [AW-1:0]      core_angle;
    logic               busy;

    // Scheduler view: takes requests and core results, drives grants, responses and core operands.
    modport slave (
        input  req_valid, req_x, req_y, core_done, core_angle,
        output req_ready, rsp_valid, rsp_angle, rsp_err, core_start, core_x, core_y, busy
    );

    // Environment view: requesters plus the CORDIC core.
    modport master (
        output req_valid, req_x, req_y, core_done, core_angle,
        input  req_ready, rsp_valid, rsp_angle, rsp_err, core_start, core_x, core_y, busy
    );
endinterface

// File: rtl/cordic_sched.sv
// rtl/cordic_sched.sv - round-robin owner of a single CORDIC angle core with watchdog abort
module cordic_sched #(
    parameter int NREQ    = 4,
    parameter int XW      = 31,
    parameter int AW      = 27,
    parameter int TIMEOUT = 64
) (
    input  logic          PCLK,
    input  logic          PRESET,
    cordic_sched_if.slave bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   last_grant, last_grant_nxt;
    logic [GW-1:0]   pick, cand;
    logic            found;
    logic [CW-1:0]   cnt, cnt_nxt;

    logic [NREQ-1:0] req_ready_q, req_ready_nxt;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_nxt;
    logic [AW-1:0]   rsp_angle_q, rsp_angle_nxt;
    logic            rsp_err_q, rsp_err_nxt;
    logic            core_start_q, core_start_nxt;
    logic [XW-1:0]   core_x_q, core_x_nxt;
    logic [XW-1:0]   core_y_q, core_y_nxt;
    logic            busy_q, busy_nxt;

    // Rotating-priority search: first requester at or after last_grant+1, wrapping around.
    always_comb begin
        pick  = last_grant;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(last_grant) + k) % NREQ);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        cnt_nxt        = cnt;
        req_ready_nxt  = '0;
        rsp_valid_nxt  = '0;
        core_start_nxt = 1'b0;
        rsp_angle_nxt  = rsp_angle_q;
        rsp_err_nxt    = rsp_err_q;
        core_x_nxt     = core_x_q;
        core_y_nxt     = core_y_q;

        case (state)
            IDLE: begin
                if (found) begin
                    last_grant_nxt = pick;
                    core_x_nxt     = bus.req_x[int'(pick)*XW +: XW];
                    core_y_nxt     = bus.req_y[int'(pick)*XW +: XW];
                    req_ready_nxt  = NREQ'(1) << pick;
                    core_start_nxt = 1'b1;
                    state_nxt      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A done arriving on the last watchdog cycle still counts as success.
                if (bus.core_done) begin
                    rsp_angle_nxt = bus.core_angle;
                    rsp_err_nxt   = 1'b0;
                    rsp_valid_nxt = NREQ'(1) << last_grant;
                    state_nxt     = RESP;
                end else if (cnt == CNT_LAST) begin
                    rsp_angle_nxt = '0;
                    rsp_err_nxt   = 1'b1;
                    rsp_valid_nxt = NREQ'(1) << last_grant;
                    state_nxt     = RESP;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers; reset drops any in-flight transaction silently.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state        <= IDLE;
            last_grant   <= GW'(NREQ - 1);
            cnt          <= '0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_angle_q  <= '0;
            rsp_err_q    <= 1'b0;
            core_start_q <= 1'b0;
            core_x_q     <= '0;
            core_y_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            state        <= state_nxt;
            last_grant   <= last_grant_nxt;
            cnt          <= cnt_nxt;
            req_ready_q  <= req_ready_nxt;
            rsp_valid_q  <= rsp_valid_nxt;
            rsp_angle_q  <= rsp_angle_nxt;
            rsp_err_q    <= rsp_err_nxt;
            core_start_q <= core_start_nxt;
            core_x_q     <= core_x_nxt;
            core_y_q     <= core_y_nxt;
            busy_q       <= busy_nxt;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_angle  = rsp_angle_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.core_start = core_start_q;
    assign bus.core_x     = core_x_q;
    assign bus.core_y     = core_y_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_cordic_sched.sv
// tb/tb_cordic_sched.sv - self-checking bench for cordic_sched against a transaction-level model
module tb_cordic_sched;
    localparam int NREQ    = 4;
    localparam int XW      = 31;
    localparam int AW      = 27;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    cordic_sched_if #(.NREQ(NREQ), .XW(XW), .AW(AW)) bus ();

    cordic_sched #(.NREQ(NREQ), .XW(XW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (bus)
    );

    int              n_assert = 0;
    int              n_fail   = 0;
    int              model_last;
    logic [AW-1:0]   model_angle;
    logic [XW-1:0]   opx [NREQ];
    logic [XW-1:0]   opy [NREQ];
    logic [NREQ-1:0] mask;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".req_ready"},  64'(bus.req_ready),  64'd0);
        chk({tag, ".rsp_valid"},  64'(bus.rsp_valid),  64'd0);
        chk({tag, ".rsp_angle"},  64'(bus.rsp_angle),  64'd0);
        chk({tag, ".rsp_err"},    64'(bus.rsp_err),    64'd0);
        chk({tag, ".core_start"}, 64'(bus.core_start), 64'd0);
        chk({tag, ".core_x"},     64'(bus.core_x),     64'd0);
        chk({tag, ".core_y"},     64'(bus.core_y),     64'd0);
        chk({tag, ".busy"},       64'(bus.busy),       64'd0);
    endtask

    task automatic drive_reqs();
        bus.req_valid = mask;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_x[i*XW +: XW] = opx[i];
            bus.req_y[i*XW +: XW] = opy[i];
        end
    endtask

    // New requesters get fresh operands; ones already waiting keep theirs.
    task automatic add_reqs(input logic [NREQ-1:0] nb);
        for (int i = 0; i < NREQ; i++) begin
            if (((nb >> i) & 1) != 0 && ((mask >> i) & 1) == 0) begin
                opx[i] = XW'($urandom());
                opy[i] = XW'($urandom());
            end
        end
        mask = mask | nb;
    endtask

    // Round-robin rule: first requesting index after the last grant, wrapping.
    function automatic int model_pick(input logic [NREQ-1:0] m);
        for (int k = 1; k <= NREQ; k++) begin
            if (((m >> ((model_last + k) % NREQ)) & 1) != 0) return (model_last + k) % NREQ;
        end
        return -1;
    endfunction

    // One transaction starting in IDLE; lat = WAIT cycle index where done is raised (<0: never).
    task automatic run_txn(input string name, input int lat, input logic [AW-1:0] ang);
        int            g;
        logic          exp_err;
        logic [AW-1:0] exp_ang;
        g = model_pick(mask);
        drive_reqs();
        @(negedge clk);
        chk({name, ".req_ready"},  64'(bus.req_ready), 64'(1) << g);
        chk({name, ".core_start"}, 64'(bus.core_start), 64'd1);
        chk({name, ".busy"},       64'(bus.busy), 64'd1);
        chk({name, ".core_x"},     64'(bus.core_x), 64'(opx[g]));
        chk({name, ".core_y"},     64'(bus.core_y), 64'(opy[g]));
        mask = mask & ~(NREQ'(1) << g);
        bus.req_valid = mask;
        model_last = g;
        exp_err = 1'b1;
        exp_ang = '0;
        @(negedge clk);
        chk({name, ".start_pulse"}, 64'(bus.core_start), 64'd0);
        chk({name, ".ready_pulse"}, 64'(bus.req_ready), 64'd0);
        for (int k = 0; k < TIMEOUT; k++) begin
            chk({name, ".early_rsp"}, 64'(bus.rsp_valid), 64'd0);
            if (k == lat) begin
                bus.core_done  = 1'b1;
                bus.core_angle = ang;
                exp_err = 1'b0;
                exp_ang = ang;
            end else begin
                bus.core_angle = AW'($urandom());
            end
            @(negedge clk);
            bus.core_done = 1'b0;
            if (k == lat) break;
        end
        chk({name, ".rsp_valid"}, 64'(bus.rsp_valid), 64'(1) << g);
        chk({name, ".rsp_err"},   64'(bus.rsp_err), 64'(exp_err));
        chk({name, ".rsp_angle"}, 64'(bus.rsp_angle), 64'(exp_ang));
        chk({name, ".x_stable"},  64'(bus.core_x), 64'(opx[g]));
        model_angle = exp_ang;
        @(negedge clk);
        chk({name, ".rsp_pulse"}, 64'(bus.rsp_valid), 64'd0);
        chk({name, ".idle"},      64'(bus.busy), 64'd0);
        chk({name, ".held"},      64'(bus.rsp_angle), 64'(exp_ang));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_last  = NREQ - 1;
        model_angle = '0;
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.core_done  = 1'b0;
        bus.core_angle = '0;
        mask        = '0;
        model_last  = NREQ - 1;
        model_angle = '0;
        for (int i = 0; i < NREQ; i++) begin
            opx[i] = '0;
            opy[i] = '0;
        end

        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        bus.core_done  = 1'b1;
        bus.core_angle = AW'($urandom());
        repeat (3) begin
            @(negedge clk);
            chk("spur0.busy",      64'(bus.busy), 64'd0);
            chk("spur0.rsp_valid", 64'(bus.rsp_valid), 64'd0);
            chk("spur0.start",     64'(bus.core_start), 64'd0);
            chk("spur0.angle",     64'(bus.rsp_angle), 64'd0);
        end
        bus.core_done = 1'b0;

        opx[2] = 31'h0010_0000;
        opy[2] = 31'h0010_0000;
        mask   = 4'b0100;
        run_txn("single", 9, 27'h019_0000);

        bus.core_done  = 1'b1;
        bus.core_angle = AW'($urandom());
        repeat (2) begin
            @(negedge clk);
            chk("spur1.busy",  64'(bus.busy), 64'd0);
            chk("spur1.angle", 64'(bus.rsp_angle), 64'(model_angle));
            chk("spur1.ready", 64'(bus.req_ready), 64'd0);
        end
        bus.core_done = 1'b0;

        do_reset();
        for (int t = 0; t < 5; t++) begin
            add_reqs('1);
            run_txn("rr", 4, AW'($urandom()));
        end

        for (int t = 0; t < 8; t++) begin
            add_reqs(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
            run_txn("rand", $urandom_range(0, 15), AW'($urandom()));
        end

        add_reqs(4'b0010);
        run_txn("timeout", -1, AW'($urandom()));

        add_reqs(4'b1000);
        run_txn("boundary", TIMEOUT - 1, AW'($urandom()));

        mask = '0;
        add_reqs(4'b0100);
        drive_reqs();
        @(negedge clk);
        mask = '0;
        bus.req_valid = mask;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_all_zero("midwait");
        @(negedge clk);
        chk("midwait.no_rsp", 64'(bus.rsp_valid), 64'd0);
        rst = 1'b0;
        model_last  = NREQ - 1;
        model_angle = '0;
        add_reqs(4'b1010);
        run_txn("post_reset", 2, AW'($urandom()));
        run_txn("post_reset2", 0, AW'($urandom()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
